fpu_sched: RTL and testbench
============================

Name: fpu_sched

Overview:
- Sequencer and two-port arbiter in front of the multi-cycle FPU micro-program engine.
- Accepts FP operation requests from two requesters, each with a valid/ready handshake. Grants them round-robin.
- For each granted request: latches the operands, pulses the FPU enable for one cycle, waits for the FPU busy to fall, then returns the result to the owning requester with its tag.
- A watchdog aborts any operation that exceeds TIMEOUT cycles.

Parameters:
- TAG_W, 5, width of the requester tag (e.g. destination register index) carried through to the response.
- TIMEOUT, 64, maximum WAIT-state cycles before abort; must be >= 2.
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  2  request valid, bit n = requester n.
- req_ready_o  out  2  request accepted this cycle, bit n = requester n.
- req_instr_i  in  60  instr[31:2] per requester; requester n at [n*30 +: 30].
- req_rs1_i, req_rs2_i, req_rs3_i  in  64 each  operands; requester n at [n*32 +: 32].
- req_tag_i  in  2*TAG_W  tag; requester n at [n*TAG_W +: TAG_W].
- fpu_enable_o  out  1  one-cycle start pulse to the FPU.
- fpu_instr_o  out  30  latched instr[31:2] to the FPU.
- fpu_rs1_o, fpu_rs2_o, fpu_rs3_o  out  32 each  latched operands to the FPU.
- fpu_busy_i  in  1  FPU busy.
- fpu_out_i  in  32  FPU result.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  1  index of the requester that owns the response.
- rsp_tag_o  out  TAG_W  tag echoed from the request.
- rsp_data_o  out  32  result; 0 on timeout.
- rsp_timeout_o  out  1  operation aborted by the watchdog.
- sched_busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_i low, asynchronous):
  - state goes to IDLE; last_grant=1, so requester 0 wins the first tie.
  - All outputs are 0. Latched operand, instr, tag and data registers are 0. Wait counter is 0.
  - Reset mid-operation abandons the operation silently; no response is produced. The FPU has its own reset.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Grant: if exactly one req_valid_i bit is set, that requester is granted. If both are set, the requester != last_grant is granted.
  - req_ready_o is combinational, asserted only for the granted bit and only in IDLE.
  - On handshake: latch instr, rs1, rs2, rs3, tag and id; update last_grant; go to LAUNCH.
  - req_ready_o is 0 in every other state.
- LAUNCH (1 cycle):
  - fpu_enable_o=1. fpu_instr_o and fpu_rs*_o are driven from the latches.
  - These outputs stay stable from LAUNCH until leaving WAIT.
  - Wait counter is cleared. Next state is WAIT.
- WAIT:
  - fpu_enable_o=0 and the counter increments each cycle.
  - The FPU raises busy one cycle after enable, so fpu_busy_i is ignored while counter==0.
  - If counter>=1 and fpu_busy_i==0: capture fpu_out_i into rsp_data, rsp_timeout=0, go to RESP.
  - Else if counter==TIMEOUT-1 and busy is still high: rsp_data=0, rsp_timeout=1, go to RESP.
  - If both conditions hold in the same cycle, completion wins.
- RESP:
  - rsp_valid_o=1 with stable rsp_id_o, rsp_tag_o, rsp_data_o and rsp_timeout_o until rsp_ready_i is sampled high.
  - On that handshake, go to IDLE; rsp_valid_o drops the next cycle.
  - No new request is accepted while in RESP (back-pressure to both requesters).
- Latency for an FPU whose busy is high for N>=1 cycles starting the cycle after enable, with rsp_ready held high:
  - accept at cycle T, LAUNCH at T+1, rsp_valid_o at T+N+3.
  - N=0 (busy never rises): rsp_valid_o at T+4.
- Requester obligation: payload is stable while valid is high and ready is low. The scheduler samples the payload only in the handshake cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- Reset, then req0 only (instr=30'h0000_0014, rs1=32'h3F80_0000, tag=3), FPU stub busy for N=1 cycle with fpu_out=32'h4000_0000 -> req_ready_o=2'b01 at T, fpu_enable_o high only at T+1, rsp_valid_o at T+4 with id=0, tag=3, data=32'h4000_0000, timeout=0.
- Both requesters valid continuously for 4 operations with N=5 -> grant order 0,1,0,1; each rsp_valid_o 8 cycles after its accept; rsp_id_o alternates.
- Stub busy stuck high, TIMEOUT=64 -> rsp_valid_o with timeout=1 and data=0 exactly 64 WAIT cycles after LAUNCH; next request is then accepted normally.
- Hold rsp_ready_i low for 10 cycles in RESP with req1 valid -> req_ready_o stays 0 and the rsp_* outputs stay stable; req1 is accepted in the first IDLE cycle after the response handshake.
- Assert reset_i low for 1 cycle during WAIT -> all outputs 0 immediately (asynchronously); no response is emitted; after release, req0 is accepted first on a tie.
- Stub with N=0 -> busy is ignored in the first WAIT cycle, result is captured in the second, rsp_valid_o at T+4.

Source files
------------

// File: rtl/fpu_sched_if.sv
// fpu_sched_if: bundles the request, FPU and response signals of the FPU
// scheduler.
//   req_*  : two requesters, valid/ready handshake, per-requester payload slices
//   fpu_*  : start pulse, latched operands, and busy/result back from the FPU
//   rsp_*  : response to the owning requester, valid/ready handshake
//   sched_busy_o : scheduler is not idle
// slave  : the scheduler's view.
// master : the environment's view (requesters, FPU and response consumer).
interface fpu_sched_if #(
  parameter int TAG_W = 5
);
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [59:0]        req_instr_i;
  logic [63:0]        req_rs1_i;
  logic [63:0]        req_rs2_i;
  logic [63:0]        req_rs3_i;
  logic [2*TAG_W-1:0] req_tag_i;

  logic               fpu_enable_o;
  logic [29:0]        fpu_instr_o;
  logic [31:0]        fpu_rs1_o;
  logic [31:0]        fpu_rs2_o;
  logic [31:0]        fpu_rs3_o;
  logic               fpu_busy_i;
  logic [31:0]        fpu_out_i;

  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic               rsp_id_o;
  logic [TAG_W-1:0]   rsp_tag_o;
  logic [31:0]        rsp_data_o;
  logic               rsp_timeout_o;
  logic               sched_busy_o;

  modport slave (
    input  req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_rs3_i, req_tag_i,
    output req_ready_o,
    output fpu_enable_o, fpu_instr_o, fpu_rs1_o, fpu_rs2_o, fpu_rs3_o,
    input  fpu_busy_i, fpu_out_i,
    output rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, rsp_timeout_o,
    input  rsp_ready_i,
    output sched_busy_o
  );

  modport master (
    output req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_rs3_i, req_tag_i,
    input  req_ready_o,
    input  fpu_enable_o, fpu_instr_o, fpu_rs1_o, fpu_rs2_o, fpu_rs3_o,
    output fpu_busy_i, fpu_out_i,
    input  rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, rsp_timeout_o,
    output rsp_ready_i,
    input  sched_busy_o
  );
endinterface

// File: rtl/fpu_sched.sv
// fpu_sched: round-robin two-port scheduler in front of the multi-cycle FPU.
// Accepts one request at a time, launches the FPU with a one-cycle enable,
// waits for busy to fall (or the watchdog to expire) and returns the result
// with the requester's id and tag.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-low reset
//   bus     : fpu_sched_if.slave (request, FPU and response signals)
module fpu_sched #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  fpu_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             id_q;
  logic [29:0]      instr_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic [31:0]      rs3_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic             timeout_q;
  logic             enable_q;
  logic             rsp_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic             gnt_id;
  logic             accept;
  logic [1:0]       ready;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_id = (&bus.req_valid_i) ? ~last_grant : bus.req_valid_i[1];
    accept = (state == S_IDLE) && (|bus.req_valid_i);
    ready  = 2'b00;
    if (accept) ready = gnt_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      id_q        <= 1'b0;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      timeout_q   <= 1'b0;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      enable_q <= 1'b0;
      case (state)
        // Handshake: sample the granted payload only in this cycle.
        S_IDLE: begin
          if (accept) begin
            instr_q    <= gnt_id ? bus.req_instr_i[59:30] : bus.req_instr_i[29:0];
            rs1_q      <= gnt_id ? bus.req_rs1_i[63:32]   : bus.req_rs1_i[31:0];
            rs2_q      <= gnt_id ? bus.req_rs2_i[63:32]   : bus.req_rs2_i[31:0];
            rs3_q      <= gnt_id ? bus.req_rs3_i[63:32]   : bus.req_rs3_i[31:0];
            tag_q      <= gnt_id ? bus.req_tag_i[2*TAG_W-1:TAG_W] : bus.req_tag_i[TAG_W-1:0];
            id_q       <= gnt_id;
            last_grant <= gnt_id;
            enable_q   <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        // Enable pulse is out this cycle; arm the watchdog.
        S_LAUNCH: begin
          cnt_q <= '0;
          state <= S_WAIT;
        end
        // Busy only rises the cycle after enable, so it means nothing at
        // cnt_q == 0. Completion is tested first so it wins over the timeout.
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if ((cnt_q != '0) && !bus.fpu_busy_i) begin
            data_q      <= bus.fpu_out_i;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            data_q      <= '0;
            timeout_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end
        // Hold the response until the consumer takes it.
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = ready;
  assign bus.fpu_enable_o  = enable_q;
  assign bus.fpu_instr_o   = instr_q;
  assign bus.fpu_rs1_o     = rs1_q;
  assign bus.fpu_rs2_o     = rs2_q;
  assign bus.fpu_rs3_o     = rs3_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_id_o      = id_q;
  assign bus.rsp_tag_o     = tag_q;
  assign bus.rsp_data_o    = data_q;
  assign bus.rsp_timeout_o = timeout_q;
  assign bus.sched_busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed testbench for fpu_sched with a behavioural FPU stub
// whose busy stays high for stub_n cycles after each enable pulse.
module tb_fpu_sched;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_sched_if #(.TAG_W(TAG_W)) bus ();

  fpu_sched #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // FPU stub
  int          stub_n   = 1;
  int          busy_cnt = 0;
  logic        stuck    = 1'b0;
  logic [31:0] stub_out = 32'h0;

  always @(posedge clk) begin
    if (bus.fpu_enable_o === 1'b1) busy_cnt <= stub_n;
    else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
  end
  assign bus.fpu_busy_i = stuck | (busy_cnt != 0);
  assign bus.fpu_out_i  = stub_out;

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  // Returns cycles from the calling cycle to the first rsp_valid_o cycle, or -1.
  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      next_cyc();
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic set_req(input int n, input logic [29:0] instr,
                         input logic [31:0] rs1, input logic [TAG_W-1:0] tag);
    bus.req_instr_i[n*30 +: 30]  = instr;
    bus.req_rs1_i[n*32 +: 32]    = rs1;
    bus.req_rs2_i[n*32 +: 32]    = ~rs1;
    bus.req_rs3_i[n*32 +: 32]    = rs1 ^ 32'h5A5A_5A5A;
    bus.req_tag_i[n*TAG_W +: TAG_W] = tag;
  endtask

  task automatic do_reset;
    rst_n           = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.req_instr_i = '0;
    bus.req_rs1_i   = '0;
    bus.req_rs2_i   = '0;
    bus.req_rs3_i   = '0;
    bus.req_tag_i   = '0;
    bus.rsp_ready_i = 1'b1;
    stuck           = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.fpu_enable_o, bus.rsp_valid_o, bus.rsp_id_o,
         bus.rsp_timeout_o, bus.sched_busy_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0", {bus.req_ready_o, bus.fpu_enable_o,
               bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_timeout_o, bus.sched_busy_o});
    end
    checks++;
    if ({bus.fpu_instr_o, bus.fpu_rs1_o, bus.fpu_rs2_o, bus.fpu_rs3_o,
         bus.rsp_tag_o, bus.rsp_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_data got instr=%h rs1=%h tag=%h data=%h want all 0",
               bus.fpu_instr_o, bus.fpu_rs1_o, bus.rsp_tag_o, bus.rsp_data_o);
    end
  endtask

  task automatic test_single;
    do_reset();
    stub_n = 1; stub_out = 32'h4000_0000; bus.rsp_ready_i = 1'b1;
    set_req(0, 30'h0000_0014, 32'h3F80_0000, 5'd3);
    bus.req_valid_i = 2'b01;
    @(negedge clk);                       // cycle T
    checks++;
    if (bus.req_ready_o !== 2'b01 || bus.fpu_enable_o !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got ready=%b en=%b want ready=01 en=0",
               bus.req_ready_o, bus.fpu_enable_o);
    end
    next_cyc(); bus.req_valid_i = 2'b00; @(negedge clk);   // T+1 LAUNCH
    checks++;
    if (bus.fpu_enable_o !== 1'b1 || bus.req_ready_o !== 2'b00 ||
        bus.fpu_instr_o !== 30'h0000_0014 || bus.fpu_rs1_o !== 32'h3F80_0000 ||
        bus.fpu_rs2_o !== 32'hC07F_FFFF || bus.fpu_rs3_o !== 32'h65DA_5A5A) begin
      failures++;
      $display("FAIL single_launch got en=%b instr=%h rs1=%h rs2=%h rs3=%h want 1 14 3f800000 c07fffff 65da5a5a",
               bus.fpu_enable_o, bus.fpu_instr_o, bus.fpu_rs1_o, bus.fpu_rs2_o, bus.fpu_rs3_o);
    end
    next_cyc(); @(negedge clk);           // T+2
    checks++;
    if (bus.fpu_enable_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.sched_busy_o !== 1'b1 ||
        bus.fpu_instr_o !== 30'h0000_0014) begin
      failures++;
      $display("FAIL single_wait got en=%b vld=%b busy=%b instr=%h want 0 0 1 14",
               bus.fpu_enable_o, bus.rsp_valid_o, bus.sched_busy_o, bus.fpu_instr_o);
    end
    next_cyc(); @(negedge clk);           // T+3
    checks++;
    if (bus.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_early_rsp got vld=%b want 0", bus.rsp_valid_o);
    end
    next_cyc(); @(negedge clk);           // T+4
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 || bus.rsp_tag_o !== 5'd3 ||
        bus.rsp_data_o !== 32'h4000_0000 || bus.rsp_timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got vld=%b id=%b tag=%0d data=%h to=%b want 1 0 3 40000000 0",
               bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_tag_o, bus.rsp_data_o, bus.rsp_timeout_o);
    end
    next_cyc(); @(negedge clk);           // T+5
    checks++;
    if (bus.rsp_valid_o !== 1'b0 || bus.sched_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got vld=%b busy=%b want 0 0", bus.rsp_valid_o, bus.sched_busy_o);
    end
  endtask

  task automatic test_round_robin;
    int lat;
    logic exp_id;
    do_reset();
    stub_n = 5; bus.rsp_ready_i = 1'b1;
    set_req(0, 30'h100, 32'h1111_0000, 5'd7);
    set_req(1, 30'h200, 32'h2222_0000, 5'd21);
    bus.req_valid_i = 2'b11;
    for (int op = 0; op < 4; op++) begin
      exp_id   = (op % 2 == 1);
      stub_out = 32'hA000_0000 + op;
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== (exp_id ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant op=%0d got ready=%b want id %0d", op, bus.req_ready_o, exp_id);
      end
      wait_rsp(lat);
      checks++;
      if (lat != 8) begin
        failures++;
        $display("FAIL rr_latency op=%0d got=%0d want=8", op, lat);
      end
      checks++;
      if (bus.rsp_id_o !== exp_id || bus.rsp_tag_o !== (exp_id ? 5'd21 : 5'd7) ||
          bus.rsp_data_o !== (32'hA000_0000 + op)) begin
        failures++;
        $display("FAIL rr_rsp op=%0d got id=%b tag=%0d data=%h", op, bus.rsp_id_o,
                 bus.rsp_tag_o, bus.rsp_data_o);
      end
      next_cyc();
    end
    bus.req_valid_i = 2'b00;
  endtask

  task automatic test_timeout;
    int lat;
    stuck = 1'b1; stub_n = 1; stub_out = 32'h1234_5678; bus.rsp_ready_i = 1'b1;
    set_req(0, 30'h3F, 32'hDEAD_BEEF, 5'd9);
    bus.req_valid_i = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL to_accept got ready=%b want 01", bus.req_ready_o);
    end
    wait_rsp(lat);
    bus.req_valid_i = 2'b00;
    checks++;
    if (lat != TIMEOUT + 2) begin
      failures++;
      $display("FAIL to_latency got=%0d want=%0d", lat, TIMEOUT + 2);
    end
    checks++;
    if (bus.rsp_timeout_o !== 1'b1 || bus.rsp_data_o !== 32'h0 || bus.rsp_tag_o !== 5'd9) begin
      failures++;
      $display("FAIL to_rsp got to=%b data=%h tag=%0d want 1 0 9",
               bus.rsp_timeout_o, bus.rsp_data_o, bus.rsp_tag_o);
    end
    next_cyc();
    stuck = 1'b0;
    stub_out = 32'h3F00_0001;
    set_req(1, 30'h40, 32'h0000_0001, 5'd10);
    bus.req_valid_i = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL to_next_accept got ready=%b want 10", bus.req_ready_o);
    end
    wait_rsp(lat);
    bus.req_valid_i = 2'b00;
    checks++;
    if (lat != 4 || bus.rsp_timeout_o !== 1'b0 || bus.rsp_data_o !== 32'h3F00_0001 ||
        bus.rsp_id_o !== 1'b1) begin
      failures++;
      $display("FAIL to_next_rsp got lat=%0d to=%b data=%h id=%b want 4 0 3f000001 1",
               lat, bus.rsp_timeout_o, bus.rsp_data_o, bus.rsp_id_o);
    end
    next_cyc();
  endtask

  task automatic test_backpressure;
    int lat;
    stub_n = 1; stub_out = 32'h0BAD_F00D; bus.rsp_ready_i = 1'b0;
    set_req(0, 30'h55, 32'h4040_0000, 5'd12);
    set_req(1, 30'h66, 32'h5050_0000, 5'd30);
    bus.req_valid_i = 2'b01;
    @(negedge clk);                       // T
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL bp_accept got ready=%b want 01", bus.req_ready_o);
    end
    next_cyc();                           // T+1
    bus.req_valid_i = 2'b10;
    wait_rsp(lat);                        // first response cycle is T+4
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=3", lat);
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin next_cyc(); @(negedge clk); end
      checks++;
      if (bus.req_ready_o !== 2'b00 || bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 ||
          bus.rsp_tag_o !== 5'd12 || bus.rsp_data_o !== 32'h0BAD_F00D || bus.rsp_timeout_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got ready=%b vld=%b id=%b tag=%0d data=%h to=%b want 00 1 0 12 0badf00d 0",
                 i, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_tag_o,
                 bus.rsp_data_o, bus.rsp_timeout_o);
      end
    end
    next_cyc();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL bp_handshake got vld=%b ready=%b want 1 00", bus.rsp_valid_o, bus.req_ready_o);
    end
    next_cyc(); @(negedge clk);           // first IDLE cycle
    checks++;
    if (bus.req_ready_o !== 2'b10 || bus.rsp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_req1_accept got ready=%b vld=%b want 10 0", bus.req_ready_o, bus.rsp_valid_o);
    end
    wait_rsp(lat);
    bus.req_valid_i = 2'b00;
    checks++;
    if (lat != 4 || bus.rsp_id_o !== 1'b1 || bus.rsp_tag_o !== 5'd30) begin
      failures++;
      $display("FAIL bp_req1_rsp got lat=%0d id=%b tag=%0d want 4 1 30", lat, bus.rsp_id_o, bus.rsp_tag_o);
    end
    next_cyc();
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    stub_n = 5; stub_out = 32'h7777_7777; bus.rsp_ready_i = 1'b1;
    set_req(0, 30'h77, 32'h7777_0000, 5'd1);
    set_req(1, 30'h88, 32'h8888_0000, 5'd2);
    bus.req_valid_i = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL rm_accept got ready=%b want 01", bus.req_ready_o);
    end
    next_cyc(); bus.req_valid_i = 2'b00;  // T+1 LAUNCH
    next_cyc();                           // T+2 WAIT
    next_cyc();                           // T+3 WAIT
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.fpu_enable_o, bus.rsp_valid_o, bus.sched_busy_o,
         bus.rsp_id_o, bus.rsp_timeout_o} !== 7'b0 ||
        {bus.fpu_instr_o, bus.fpu_rs1_o, bus.fpu_rs2_o, bus.fpu_rs3_o,
         bus.rsp_tag_o, bus.rsp_data_o} !== '0) begin
      failures++;
      $display("FAIL rm_async_clear got busy=%b instr=%h rs1=%h vld=%b want all 0",
               bus.sched_busy_o, bus.fpu_instr_o, bus.fpu_rs1_o, bus.rsp_valid_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      next_cyc(); @(negedge clk);
      if (bus.rsp_valid_o !== 1'b0 || bus.sched_busy_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rm_no_rsp got active_cycles=%0d want=0", seen);
    end
    next_cyc();
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL rm_tie got ready=%b want 01", bus.req_ready_o);
    end
    wait_rsp(lat);
    bus.req_valid_i = 2'b00;
    checks++;
    if (lat != 8 || bus.rsp_id_o !== 1'b0 || bus.rsp_tag_o !== 5'd1 || bus.rsp_data_o !== 32'h7777_7777) begin
      failures++;
      $display("FAIL rm_rsp got lat=%0d id=%b tag=%0d data=%h want 8 0 1 77777777",
               lat, bus.rsp_id_o, bus.rsp_tag_o, bus.rsp_data_o);
    end
    next_cyc();
  endtask

  task automatic test_n0;
    int lat;
    stub_n = 0; stub_out = 32'hC0FF_EE00; bus.rsp_ready_i = 1'b1;
    set_req(1, 30'h99, 32'h0000_0009, 5'd4);
    bus.req_valid_i = 2'b10;
    @(negedge clk);
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL n0_accept got ready=%b want 10", bus.req_ready_o);
    end
    wait_rsp(lat);
    bus.req_valid_i = 2'b00;
    checks++;
    if (lat != 4 || bus.rsp_data_o !== 32'hC0FF_EE00 || bus.rsp_timeout_o !== 1'b0 ||
        bus.rsp_id_o !== 1'b1 || bus.rsp_tag_o !== 5'd4) begin
      failures++;
      $display("FAIL n0_rsp got lat=%0d data=%h to=%b id=%b tag=%0d want 4 c0ffee00 0 1 4",
               lat, bus.rsp_data_o, bus.rsp_timeout_o, bus.rsp_id_o, bus.rsp_tag_o);
    end
    next_cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_n0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
